// File: rtl/rv_pkg.sv
// rv_pkg: shared datapath constants and decode helpers for the register file and decode stage.
package rv_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [31:0] NOP = 32'h00000013;
  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_OPIMM  = 7'b0010011,
    OP_STORE  = 7'b0100011,
    OP_OP     = 7'b0110011,
    OP_BRANCH = 7'b1100011
  } opcode_e;
  function automatic logic is_long(input logic [6:0] op);
    return op == OP_LOAD;
  endfunction
endpackage

// File: rtl/sb_cnt.sv
// sb_cnt: per-register pending long-write counter, saturating at MAXPEND and flagging misuse.
module sb_cnt #(
  parameter int MAXPEND = 3,
  parameter int CW      = $clog2(MAXPEND + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt,
  output logic          o_full,
  output logic          o_err
);
  logic [CW-1:0] r_cnt;
  logic          w_inc, w_dec;
  assign o_cnt  = r_cnt;
  assign o_full = r_cnt == CW'(MAXPEND);
  assign w_inc  = i_inc & ~o_full;
  assign w_dec  = i_dec & (r_cnt != '0);
  assign o_err  = (i_inc & o_full) | (i_dec & (r_cnt == '0));
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (w_inc != w_dec) r_cnt <= w_inc ? r_cnt + 1'b1 : r_cnt - 1'b1;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with write-through bypass and a pending long-write scoreboard.
module regfile_sb
  import rv_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter int MAXPEND = 3,
  localparam int AW     = $clog2(NREG),
  localparam int CW     = $clog2(MAXPEND + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NRD-1:0]    rd_used,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  output logic              stall,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_full,
  input  logic              wr_en,
  input  logic              wr_long,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  output logic              sb_err
);
  logic [XLEN-1:0]          r_regs [NREG];
  logic [NREG-1:0][CW-1:0]  w_cnt;
  logic [NREG-1:0]          w_full, w_err;
  logic                     r_sb_err;
  logic                     w_done;
  assign w_done   = wr_en & wr_long;
  assign iss_full = w_full[iss_rd];
  assign sb_err   = r_sb_err;
  assign stall    = |(rd_busy & rd_used);
  // x0 has no counter: it is never busy and never raises an error
  assign w_cnt[0]  = '0;
  assign w_full[0] = 1'b0;
  assign w_err[0]  = 1'b0;
  for (genvar g = 1; g < NREG; g++) begin : g_sb
    sb_cnt #(.MAXPEND(MAXPEND), .CW(CW)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .i_inc (iss_valid && iss_rd == AW'(g)),
      .i_dec (w_done && wr_addr == AW'(g)),
      .o_cnt (w_cnt[g]),
      .o_full(w_full[g]),
      .o_err (w_err[g])
    );
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_sb_err <= 1'b0;
    else if (|w_err) r_sb_err <= 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
    else if (wr_en && wr_addr != '0) r_regs[wr_addr] <= wr_data;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_byp;
    assign w_ra  = rd_addr[i*AW +: AW];
    // bypass is suppressed during reset so reads stay 0 while reset is held
    assign w_byp = reset && wr_en && wr_addr == w_ra && w_ra != '0;
    assign rd_data[i*XLEN +: XLEN] = w_byp ? wr_data : r_regs[w_ra];
    assign rd_busy[i] = w_cnt[w_ra] != '0 && !(w_cnt[w_ra] == CW'(1) && w_done && wr_addr == w_ra);
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven and sequence checks of regfile_sb with an expected-value queue.
module tb_regfile_sb;
  logic        clk = 0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_used, rd_busy;
  logic [63:0] rd_data;
  logic        stall, iss_valid, iss_full, wr_en, wr_long, sb_err;
  logic [4:0]  iss_rd, wr_addr;
  logic [31:0] wr_data;
  logic [14:0] t3_rd_addr;
  logic [2:0]  t3_rd_used, t3_rd_busy;
  logic [95:0] t3_rd_data;
  logic        t3_stall, t3_iss_valid, t3_iss_full, t3_wr_en, t3_wr_long, t3_sb_err;
  logic [4:0]  t3_iss_rd, t3_wr_addr;
  logic [31:0] t3_wr_data;
  int total = 0, bad = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd;
    logic [4:0] ra0, ra1; logic [31:0] e0, e1;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_used(rd_used), .rd_data(rd_data),
    .rd_busy(rd_busy), .stall(stall), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .iss_full(iss_full), .wr_en(wr_en), .wr_long(wr_long), .wr_addr(wr_addr),
    .wr_data(wr_data), .sb_err(sb_err)
  );
  regfile_sb #(.NRD(3)) dut3 (
    .clk(clk), .reset(reset), .rd_addr(t3_rd_addr), .rd_used(t3_rd_used), .rd_data(t3_rd_data),
    .rd_busy(t3_rd_busy), .stall(t3_stall), .iss_valid(t3_iss_valid), .iss_rd(t3_iss_rd),
    .iss_full(t3_iss_full), .wr_en(t3_wr_en), .wr_long(t3_wr_long), .wr_addr(t3_wr_addr),
    .wr_data(t3_wr_data), .sb_err(t3_sb_err)
  );

  task automatic expect_v(input logic [63:0] v);
    exp_q.push_back(v);
  endtask
  task automatic cmp(input string n, input logic [63:0] act);
    logic [63:0] e;
    e = exp_q.pop_front();
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, act, e);
    end
  endtask
  task automatic idle();
    iss_valid = 0; iss_rd = 0; wr_en = 0; wr_long = 0; wr_addr = 0; wr_data = 0;
    rd_used = 0;
    t3_iss_valid = 0; t3_iss_rd = 0; t3_wr_en = 0; t3_wr_long = 0; t3_wr_addr = 0;
    t3_wr_data = 0; t3_rd_used = 0; t3_rd_addr = 0;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    tbl[0] = '{1, 5'd1,  32'h11,       5'd1,  5'd0,  32'h11,       32'h0};
    tbl[1] = '{1, 5'd2,  32'h22,       5'd1,  5'd2,  32'h11,       32'h22};
    tbl[2] = '{1, 5'd1,  32'h33,       5'd1,  5'd2,  32'h33,       32'h22};
    tbl[3] = '{0, 5'd2,  32'h99,       5'd2,  5'd1,  32'h22,       32'h33};
    tbl[4] = '{1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd5,  32'hFFFFFFFF, 32'hDEADBEEF};
    tbl[5] = '{1, 5'd0,  32'h77,       5'd0,  5'd31, 32'h0,        32'hFFFFFFFF};
    reset = 0; idle(); rd(0, 0);
    #2;
    wr_en = 1; wr_addr = 5; wr_data = 32'hAAAA5555; rd(5, 0);
    iss_rd = 3;
    expect_v(0); expect_v(0); expect_v(0); expect_v(0);
    #1;
    cmp("reset_rd_data", rd_data);
    cmp("reset_busy", {62'b0, rd_busy});
    cmp("reset_iss_full", {63'b0, iss_full});
    cmp("reset_sb_err", {63'b0, sb_err});
    #9 reset = 1; idle();
    tick();
    // bypass then array read
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rd(5, 0);
    expect_v(64'hDEADBEEF); #3 cmp("bypass_x5", {32'b0, rd_data[31:0]});
    tick(); idle();
    expect_v(64'hDEADBEEF); #3 cmp("array_x5", {32'b0, rd_data[31:0]});
    tick();
    wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rd(0, 0);
    expect_v(0); #3 cmp("x0_bypass", {32'b0, rd_data[31:0]});
    tick(); idle();
    expect_v(0); #3 cmp("x0_array", {32'b0, rd_data[31:0]});
    tick();
    for (int i = 0; i < 6; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; rd(tbl[i].ra0, tbl[i].ra1);
      expect_v({tbl[i].e1, tbl[i].e0});
      #3 cmp($sformatf("tbl%0d", i), rd_data);
      tick();
    end
    idle();
    // x7 long write: busy from the cycle after issue, cleared by completion bypass
    iss_valid = 1; iss_rd = 7; rd(0, 7); rd_used = 2'b10;
    expect_v(0); #3 cmp("x7_busy_issue_cycle", {62'b0, rd_busy});
    tick(); iss_valid = 0;
    expect_v(2'b10); expect_v(1);
    #3 cmp("x7_busy", {62'b0, rd_busy}); cmp("x7_stall", {63'b0, stall});
    tick();
    wr_en = 1; wr_long = 1; wr_addr = 7; wr_data = 32'h42;
    expect_v(0); expect_v(0); expect_v(32'h42);
    #3 cmp("x7_done_busy", {62'b0, rd_busy}); cmp("x7_done_stall", {63'b0, stall});
    cmp("x7_done_data", {32'b0, rd_data[63:32]});
    tick(); idle(); rd_used = 2'b10;
    expect_v(0); expect_v(32'h42);
    #3 cmp("x7_after_busy", {62'b0, rd_busy}); cmp("x7_after_data", {32'b0, rd_data[63:32]});
    tick(); idle();
    // x3 saturation
    iss_valid = 1; iss_rd = 3;
    tick(); tick(); tick();
    expect_v(1); expect_v(0);
    #3 cmp("x3_full", {63'b0, iss_full}); cmp("x3_err_before", {63'b0, sb_err});
    tick(); iss_valid = 0;
    expect_v(1); expect_v(1);
    #3 cmp("x3_err_sticky", {63'b0, sb_err}); cmp("x3_still_full", {63'b0, iss_full});
    tick();
    wr_en = 1; wr_long = 1; wr_addr = 3; wr_data = 32'h3; rd(3, 0); rd_used = 2'b01;
    for (int k = 0; k < 3; k++) begin
      expect_v(k < 2 ? 64'd1 : 64'd0);
      #3 cmp($sformatf("x3_done%0d_busy", k), {62'b0, rd_busy});
      tick();
    end
    idle(); iss_rd = 3; rd(3, 0);
    expect_v(0); expect_v(0);
    #3 cmp("x3_idle_busy", {62'b0, rd_busy}); cmp("x3_not_full", {63'b0, iss_full});
    tick();
    // x9 simultaneous issue and completion keeps count at 1
    iss_valid = 1; iss_rd = 9;
    tick();
    wr_en = 1; wr_long = 1; wr_addr = 9; wr_data = 32'h9; rd(9, 0);
    expect_v(0); #3 cmp("x9_same_cycle_busy", {62'b0, rd_busy});
    tick(); idle(); rd_used = 2'b00;
    expect_v(1); expect_v(0);
    #3 cmp("x9_next_busy", {62'b0, rd_busy}); cmp("x9_unused_stall", {63'b0, stall});
    tick();
    wr_en = 1; wr_long = 1; wr_addr = 9;
    tick(); idle();
    expect_v(0); #3 cmp("x9_cleared", {62'b0, rd_busy});
    tick();
    // three-port instance: busy only on port 2
    t3_iss_valid = 1; t3_iss_rd = 8;
    tick(); t3_iss_valid = 0; t3_rd_addr = {5'd8, 5'd0, 5'd0}; t3_rd_used = 3'b111;
    expect_v(3'b100); expect_v(1);
    #3 cmp("nrd3_busy", {61'b0, t3_rd_busy}); cmp("nrd3_stall", {63'b0, t3_stall});
    tick(); idle();
    // reset with pending counts
    wr_en = 1; wr_addr = 4; wr_data = 32'h55;
    tick(); idle(); iss_valid = 1; iss_rd = 4;
    tick(); iss_rd = 6;
    tick(); idle(); rd(4, 6); rd_used = 2'b11;
    expect_v(1); expect_v(32'h55);
    #3 cmp("pre_reset_stall", {63'b0, stall}); cmp("pre_reset_x4", {32'b0, rd_data[31:0]});
    tick(); #1 reset = 0;
    expect_v(0); expect_v(0); expect_v(0); expect_v(0);
    #1 cmp("mid_reset_busy", {62'b0, rd_busy}); cmp("mid_reset_stall", {63'b0, stall});
    cmp("mid_reset_data", rd_data); cmp("mid_reset_err", {63'b0, sb_err});
    #2 reset = 1;
    tick(); iss_rd = 4;
    expect_v(0); expect_v(0); expect_v(0);
    #3 cmp("post_reset_x4", {32'b0, rd_data[31:0]}); cmp("post_reset_busy", {62'b0, rd_busy});
    cmp("post_reset_full", {63'b0, iss_full});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
